// File: rtl/multicycle_control.sv
// Multi-cycle sequencing FSM for the shared-ALU / shared-memory MIPS datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback and aborts hung memory accesses.
module multicycle_control #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] aluop,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state
);

  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIM_M1 = (WAIT_LIMIT > 0) ? CW'(WAIT_LIMIT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX = '1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t        st, nxt;
  logic [CW-1:0] wcnt, wcnt_nxt;
  logic          mem_state, timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= S_FETCH;
      wcnt <= '0;
    end else begin
      st   <= nxt;
      wcnt <= wcnt_nxt;
    end
  end

  assign state = st;

  // Wait counter only runs while a memory access is stalled; any completion or abort clears it.
  always_comb begin
    mem_state = (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
    timeout   = (WAIT_LIMIT > 0) && mem_state && !mem_ready && (wcnt == LIM_M1);
    wcnt_nxt  = '0;
    if (mem_state && !mem_ready && !timeout)
      wcnt_nxt = (wcnt == CNT_MAX) ? wcnt : wcnt + CW'(1);
  end

  always_comb begin
    nxt           = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aluop         = 3'b000;
    illegal_op    = 1'b0;
    bus_error     = 1'b0;
    case (st)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        nxt       = S_FETCH;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else if (timeout) begin
          bus_error = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:    nxt = S_MEMADR;
          OP_RTYPE:        nxt = S_EXEC;
          OP_BEQ, OP_BNE:  nxt = S_BRANCH;
          OP_ADDI, OP_ORI: nxt = S_IEXEC;
          OP_J:            nxt = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            nxt        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        nxt      = S_MEMRD;
        if (mem_ready) begin
          nxt = S_MEMWB;
        end else if (timeout) begin
          bus_error = 1'b1;
          nxt       = S_FETCH;
        end
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        nxt       = S_MEMWR;
        if (mem_ready) begin
          nxt = S_FETCH;
        end else if (timeout) begin
          bus_error = 1'b1;
          nxt       = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = 3'b111;
        nxt       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == OP_BNE);
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluop     = (opcode == OP_ORI) ? 3'b011 : 3'b000;
        nxt       = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: nxt = S_FETCH;
    endcase
    // Reset holds the datapath idle so nothing is written in the reset cycle.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      pc_source     = 2'b00;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      aluop         = 3'b000;
      illegal_op    = 1'b0;
      bus_error     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state and control word queued at drive time.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op, bus_error;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] aluop;
  logic [3:0] state;

  multicycle_control #(.WAIT_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .illegal_op(illegal_op), .bus_error(bus_error), .state(state)
  );

  always #5 clk = ~clk;

  logic [19:0] ctl_obs;
  assign ctl_obs = {pc_write, pc_write_cond, branch_ne, pc_source, iord, mem_read, mem_write,
                    ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, aluop,
                    illegal_op, bus_error};

  typedef struct {
    logic [3:0]  st;
    logic [19:0] ctl;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Field order matches ctl_obs.
  function automatic logic [19:0] mk(input logic pw, input logic pwc, input logic bne,
                                     input logic [1:0] ps, input logic io, input logic mr,
                                     input logic mw, input logic irw, input logic rd,
                                     input logic m2r, input logic rw, input logic a,
                                     input logic [1:0] b, input logic [2:0] op,
                                     input logic ill, input logic be);
    return {pw, pwc, bne, ps, io, mr, mw, irw, rd, m2r, rw, a, b, op, ill, be};
  endfunction

  logic [19:0] C_FETCH, C_FDONE, C_FBE, C_DEC, C_ILL, C_MADR, C_MRD, C_MRDBE, C_MWB;
  logic [19:0] C_MWR, C_MWRBE, C_EXEC, C_AWB, C_BNE, C_BEQ, C_ADDI, C_ORI, C_IWB, C_JMP;

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check({e.tag, "/state"}, 32'(state), 32'(e.st));
      check({e.tag, "/ctl"}, 32'(ctl_obs), 32'(e.ctl));
    end
  end

  task automatic cyc(input logic r, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [19:0] c, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    opcode    = op;
    mem_ready = rdy;
    e.st  = st;
    e.ctl = c;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  initial begin
    C_FETCH = mk(0,0,0,2'b00,0,1,0,0,0,0,0,0,2'b01,3'b000,0,0);
    C_FDONE = mk(1,0,0,2'b00,0,1,0,1,0,0,0,0,2'b01,3'b000,0,0);
    C_FBE   = mk(0,0,0,2'b00,0,1,0,0,0,0,0,0,2'b01,3'b000,0,1);
    C_DEC   = mk(0,0,0,2'b00,0,0,0,0,0,0,0,0,2'b11,3'b000,0,0);
    C_ILL   = mk(0,0,0,2'b00,0,0,0,0,0,0,0,0,2'b11,3'b000,1,0);
    C_MADR  = mk(0,0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,3'b000,0,0);
    C_MRD   = mk(0,0,0,2'b00,1,1,0,0,0,0,0,0,2'b00,3'b000,0,0);
    C_MRDBE = mk(0,0,0,2'b00,1,1,0,0,0,0,0,0,2'b00,3'b000,0,1);
    C_MWB   = mk(0,0,0,2'b00,0,0,0,0,0,1,1,0,2'b00,3'b000,0,0);
    C_MWR   = mk(0,0,0,2'b00,1,0,1,0,0,0,0,0,2'b00,3'b000,0,0);
    C_MWRBE = mk(0,0,0,2'b00,1,0,1,0,0,0,0,0,2'b00,3'b000,0,1);
    C_EXEC  = mk(0,0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,3'b111,0,0);
    C_AWB   = mk(0,0,0,2'b00,0,0,0,0,1,0,1,0,2'b00,3'b000,0,0);
    C_BNE   = mk(0,1,1,2'b01,0,0,0,0,0,0,0,1,2'b00,3'b001,0,0);
    C_BEQ   = mk(0,1,0,2'b01,0,0,0,0,0,0,0,1,2'b00,3'b001,0,0);
    C_ADDI  = mk(0,0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,3'b000,0,0);
    C_ORI   = mk(0,0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,3'b011,0,0);
    C_IWB   = mk(0,0,0,2'b00,0,0,0,0,0,0,1,0,2'b00,3'b000,0,0);
    C_JMP   = mk(1,0,0,2'b10,0,0,0,0,0,0,0,0,2'b00,3'b000,0,0);

    rst = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    cyc(1, 6'b000000, 1, 4'd0, 20'd0, "rst0");
    cyc(1, 6'b000000, 1, 4'd0, 20'd0, "rst1");

    // R-type, zero wait states
    cyc(0, 6'b000000, 1, 4'd0, C_FDONE, "r_fetch");
    cyc(0, 6'b000000, 1, 4'd1, C_DEC,   "r_dec");
    cyc(0, 6'b000000, 1, 4'd6, C_EXEC,  "r_exec");
    cyc(0, 6'b000000, 1, 4'd7, C_AWB,   "r_wb");

    // lw with 3 wait cycles in MEMRD
    cyc(0, 6'b100011, 1, 4'd0, C_FDONE, "lw_fetch");
    cyc(0, 6'b100011, 1, 4'd1, C_DEC,   "lw_dec");
    cyc(0, 6'b100011, 1, 4'd2, C_MADR,  "lw_adr");
    for (int i = 0; i < 3; i++) cyc(0, 6'b100011, 0, 4'd3, C_MRD, "lw_wait");
    cyc(0, 6'b100011, 1, 4'd3, C_MRD,   "lw_rd");
    cyc(0, 6'b100011, 1, 4'd4, C_MWB,   "lw_wb");

    // bne, beq
    cyc(0, 6'b000101, 1, 4'd0, C_FDONE, "bne_fetch");
    cyc(0, 6'b000101, 1, 4'd1, C_DEC,   "bne_dec");
    cyc(0, 6'b000101, 1, 4'd8, C_BNE,   "bne_br");
    cyc(0, 6'b000100, 1, 4'd0, C_FDONE, "beq_fetch");
    cyc(0, 6'b000100, 1, 4'd1, C_DEC,   "beq_dec");
    cyc(0, 6'b000100, 1, 4'd8, C_BEQ,   "beq_br");

    // addi, ori, j
    cyc(0, 6'b001000, 1, 4'd0,  C_FDONE, "addi_fetch");
    cyc(0, 6'b001000, 1, 4'd1,  C_DEC,   "addi_dec");
    cyc(0, 6'b001000, 1, 4'd9,  C_ADDI,  "addi_ex");
    cyc(0, 6'b001000, 1, 4'd10, C_IWB,   "addi_wb");
    cyc(0, 6'b001101, 1, 4'd0,  C_FDONE, "ori_fetch");
    cyc(0, 6'b001101, 1, 4'd1,  C_DEC,   "ori_dec");
    cyc(0, 6'b001101, 1, 4'd9,  C_ORI,   "ori_ex");
    cyc(0, 6'b001101, 1, 4'd10, C_IWB,   "ori_wb");
    cyc(0, 6'b000010, 1, 4'd0,  C_FDONE, "j_fetch");
    cyc(0, 6'b000010, 1, 4'd1,  C_DEC,   "j_dec");
    cyc(0, 6'b000010, 1, 4'd11, C_JMP,   "j_jump");

    // illegal opcode
    cyc(0, 6'b111111, 1, 4'd0, C_FDONE, "ill_fetch");
    cyc(0, 6'b111111, 1, 4'd1, C_ILL,   "ill_dec");

    // sw with a completed write after one wait, then sw that times out
    cyc(0, 6'b101011, 1, 4'd0, C_FDONE, "sw_fetch");
    cyc(0, 6'b101011, 1, 4'd1, C_DEC,   "sw_dec");
    cyc(0, 6'b101011, 1, 4'd2, C_MADR,  "sw_adr");
    cyc(0, 6'b101011, 0, 4'd5, C_MWR,   "sw_wait");
    cyc(0, 6'b101011, 1, 4'd5, C_MWR,   "sw_wr");
    cyc(0, 6'b101011, 1, 4'd0, C_FDONE, "swto_fetch");
    cyc(0, 6'b101011, 1, 4'd1, C_DEC,   "swto_dec");
    cyc(0, 6'b101011, 1, 4'd2, C_MADR,  "swto_adr");
    for (int i = 0; i < 16; i++)
      cyc(0, 6'b101011, 0, 4'd5, (i == 15) ? C_MWRBE : C_MWR, "swto_wr");

    // FETCH stalls then times out, then refetches without pc_write
    cyc(0, 6'b100011, 0, 4'd0, C_FETCH, "f_wait");
    cyc(0, 6'b100011, 0, 4'd0, C_FETCH, "f_wait");
    cyc(0, 6'b100011, 1, 4'd0, C_FDONE, "f_done");
    cyc(0, 6'b100011, 1, 4'd1, C_DEC,   "lwc_dec");
    cyc(0, 6'b100011, 1, 4'd2, C_MADR,  "lwc_adr");
    // completion on the would-be timeout cycle wins
    for (int i = 0; i < 15; i++) cyc(0, 6'b100011, 0, 4'd3, C_MRD, "lwc_wait");
    cyc(0, 6'b100011, 1, 4'd3, C_MRD, "lwc_rd16");
    cyc(0, 6'b100011, 1, 4'd4, C_MWB, "lwc_wb");
    for (int i = 0; i < 16; i++)
      cyc(0, 6'b100011, 0, 4'd0, (i == 15) ? C_FBE : C_FETCH, "fto");
    cyc(0, 6'b100011, 1, 4'd0, C_FDONE, "lwa_fetch");
    cyc(0, 6'b100011, 1, 4'd1, C_DEC,   "lwa_dec");
    cyc(0, 6'b100011, 1, 4'd2, C_MADR,  "lwa_adr");
    // aborted MEMRD returns to FETCH with no writeback
    for (int i = 0; i < 16; i++)
      cyc(0, 6'b100011, 0, 4'd3, (i == 15) ? C_MRDBE : C_MRD, "lwa_rd");
    cyc(0, 6'b000000, 1, 4'd0, C_FDONE, "mid_fetch");
    cyc(0, 6'b000000, 1, 4'd1, C_DEC,   "mid_dec");
    // reset in EXEC abandons the instruction
    cyc(1, 6'b000000, 1, 4'd6, 20'd0,   "mid_rst");
    cyc(0, 6'b000000, 0, 4'd0, C_FETCH, "post_rst");
    cyc(0, 6'b000000, 1, 4'd0, C_FDONE, "post_fetch");

    @(posedge clk);
    @(negedge clk);
    #1;
    check("drain", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
